// File: rtl/hs_fifo.sv
// ----------------------------------------------------------------------------
// hs_fifo
//   DEPTH-entry synchronous FIFO that decouples a valid/ready producer from a
//   valid/ready consumer. The head entry is presented with first-word
//   fall-through. Occupancy is tracked by a counter, which also drives
//   full/empty, so the pointers never need to be compared.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of pointers and count (beats push/pop)
//   in_data      producer payload, sampled only on an accepted edge
//   in_valid     producer has data
//   in_ready     FIFO can accept (count != DEPTH), from registered state only
//   out_data     head-of-FIFO payload (0 while empty)
//   out_valid    head entry valid (count != 0)
//   out_ready    consumer accepts
//   count        entries held, 0..DEPTH
//   almost_full  count >= AF_LEVEL
// ----------------------------------------------------------------------------
module hs_fifo #(
    parameter  int unsigned DATA_W   = 4,
    parameter  int unsigned DEPTH    = 4,
    parameter  int unsigned AF_LEVEL = 3,
    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic push;
    logic pop;

    // Status flags depend on the count register only, so in_ready has no
    // combinational path from out_ready.
    assign in_ready    = (count_q != CNT_W'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign almost_full = (count_q >= CNT_W'(AF_LEVEL));
    assign count       = count_q;

    // Flush discards any handshake that happens in the same cycle.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Empty FIFO presents zero rather than stale storage.
    assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are never reset since out_data masks them while
    // the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
